// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//
// Turns the four debounced direction buttons into the snake's heading.
// Each button level is edge-detected against a history flop. Of the presses
// that rise in the same cycle, only the highest-priority one is kept
// (up > right > down > left). The kept press is registered and evaluated on
// the following cycle. Presses that repeat or reverse the reference heading
// are rejected. Accepted turns wait in a buffer and are applied one per
// game step.
//
// Heading encoding: 0 up, 1 right, 2 down, 3 left.
//
// Build option:
//   SNAKE_DIR_QUEUE_EN defined   - 2-entry turn queue. The reference heading
//                                  is the queue tail, or dir when the queue
//                                  is empty. q_count ranges 0..2.
//   SNAKE_DIR_QUEUE_EN undefined - single pending slot. The reference is
//                                  always dir. A valid press overwrites any
//                                  pending turn. q_count ranges 0..1.
//
// Parameters:
//   RESET_DIR  heading after reset
//
// Ports:
//   clk        system clock, shared with the debouncers
//   rst        synchronous, active-high reset
//   btn_up     debounced button level
//   btn_right  debounced button level
//   btn_down   debounced button level
//   btn_left   debounced button level
//   step       one-cycle game tick
//   dir        current heading, registered
//   turned     one-cycle pulse: dir changed on this step
//   rejected   one-cycle pulse: a press was discarded
//   q_count    number of buffered turns

module snake_dir_ctrl #(
  parameter logic [1:0] RESET_DIR = 2'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       step,
  output logic [1:0] dir,
  output logic       turned,
  output logic       rejected,
  output logic [1:0] q_count
);

  // ---------------------------------------------------------------------------
  // Edge detection and press priority
  // ---------------------------------------------------------------------------
  // Bit index equals the heading code, so the winning bit index is the
  // candidate heading.
  logic [3:0] btn_vec;
  logic [3:0] hist_q;
  logic [3:0] rise;
  logic       press_vld_d, press_vld_q;
  logic [1:0] press_dir_d, press_dir_q;

  assign btn_vec = {btn_left, btn_down, btn_right, btn_up};
  assign rise    = btn_vec & ~hist_q;

  always_comb begin
    press_vld_d = |rise;
    press_dir_d = 2'd0;
    if (rise[0]) begin
      press_dir_d = 2'd0;
    end else if (rise[1]) begin
      press_dir_d = 2'd1;
    end else if (rise[2]) begin
      press_dir_d = 2'd2;
    end else if (rise[3]) begin
      press_dir_d = 2'd3;
    end
  end

  // History resets high, so a button held through reset never produces a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= 4'b1111;
      press_vld_q <= 1'b0;
      press_dir_q <= 2'd0;
    end else begin
      hist_q      <= btn_vec;
      press_vld_q <= press_vld_d;
      press_dir_q <= press_dir_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Turn buffer
  // ---------------------------------------------------------------------------
  logic       pop;       // step consumes a buffered turn this cycle
  logic       push;      // registered press is accepted this cycle
  logic       reject;    // registered press is discarded this cycle
  logic [1:0] head_dir;  // turn applied by a pop
  logic [1:0] ref_dir;   // heading a press is compared against
  logic       is_noop;
  logic       is_rev;

  assign is_noop = (press_dir_q == ref_dir);
  assign is_rev  = (press_dir_q == (ref_dir ^ 2'b10));

`ifdef SNAKE_DIR_QUEUE_EN
  logic [1:0][1:0] slot_q;
  logic            wptr_d, wptr_q;
  logic            rptr_d, rptr_q;
  logic [1:0]      count_d, count_q;
  logic            full_after_pop;

  always_comb begin
    pop      = step && (count_q != 2'd0);
    head_dir = slot_q[rptr_q];
    // With one entry the tail equals the head, so the tail is also the
    // post-pop reference when that entry is popped this cycle.
    ref_dir  = (count_q != 2'd0) ? slot_q[wptr_q ^ 1'b1] : dir;
    // A simultaneous pop frees the slot the press would need.
    full_after_pop = (count_q == 2'd2) && !pop;
    push     = press_vld_q && !is_noop && !is_rev && !full_after_pop;
    reject   = press_vld_q && !push;
    count_d  = count_q - {1'b0, pop} + {1'b0, push};
    wptr_d   = wptr_q ^ push;
    rptr_d   = rptr_q ^ pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wptr_q] <= press_dir_q;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign q_count = count_q;
`else
  logic       pend_vld_d, pend_vld_q;
  logic [1:0] pend_dir_d, pend_dir_q;

  always_comb begin
    pop        = step && pend_vld_q;
    head_dir   = pend_dir_q;
    ref_dir    = dir;
    push       = press_vld_q && !is_noop && !is_rev;
    reject     = press_vld_q && !push;
    // A new press replaces any pending turn, including one popped this cycle.
    pend_vld_d = push || (pend_vld_q && !pop);
    pend_dir_d = push ? press_dir_q : pend_dir_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_dir_q <= 2'd0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  assign q_count = {1'b0, pend_vld_q};
`endif

  // ---------------------------------------------------------------------------
  // Heading and status pulses
  // ---------------------------------------------------------------------------
  logic [1:0] dir_d, dir_q;
  logic       turned_q;
  logic       rejected_q;

  assign dir_d = pop ? head_dir : dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= RESET_DIR;
      turned_q   <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      turned_q   <= pop;
      rejected_q <= reject;
    end
  end

  assign dir      = dir_q;
  assign turned   = turned_q;
  assign rejected = rejected_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl. It runs directed scenarios and then
// random button/step/reset traffic. The behavioural model tracks the turn
// buffer as a plain queue of headings.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       step = 1'b0;
  logic [1:0] dir;
  logic       turned;
  logic       rejected;
  logic [1:0] q_count;

  int checks = 0;
  int errors = 0;

  snake_dir_ctrl #(.RESET_DIR(2'd1)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .step      (step),
    .dir       (dir),
    .turned    (turned),
    .rejected  (rejected),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  // Behavioural model. Button index equals the heading code.
  logic [1:0] m_dir = 2'd1;
  bit         m_turned = 1'b0;
  bit         m_rejected = 1'b0;
  logic [1:0] mq[$];
  logic [3:0] m_hist = 4'hf;
  bit         m_pv = 1'b0;
  logic [1:0] m_pc = 2'd0;

  task automatic model_edge(input logic r, input logic [3:0] b, input logic s);
    logic [1:0] rdir;
    logic [1:0] old_dir;
    if (r) begin
      m_dir = 2'd1; m_turned = 0; m_rejected = 0; mq.delete();
      m_hist = 4'hf; m_pv = 0; m_pc = 2'd0;
    end else begin
      old_dir = m_dir;
      m_turned = 0;
      m_rejected = 0;
      if (s && mq.size() > 0) begin
        m_dir = mq.pop_front();
        m_turned = 1;
      end
      if (m_pv) begin
`ifdef SNAKE_DIR_QUEUE_EN
        rdir = (mq.size() > 0) ? mq[$] : m_dir;
        if (m_pc == rdir || m_pc == (rdir ^ 2'b10) || mq.size() >= 2) m_rejected = 1;
        else mq.push_back(m_pc);
`else
        rdir = old_dir;
        if (m_pc == rdir || m_pc == (rdir ^ 2'b10)) m_rejected = 1;
        else begin
          mq.delete();
          mq.push_back(m_pc);
        end
`endif
      end
      m_pv = 0;
      for (int i = 3; i >= 0; i--) begin
        if (b[i] && !m_hist[i]) begin
          m_pv = 1;
          m_pc = i[1:0];
        end
      end
      m_hist = b;
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, sample #1 later.
  task automatic tick(input logic r, input logic [3:0] b, input logic s);
    rst = r;
    {btn_left, btn_down, btn_right, btn_up} = b;
    step = s;
    @(posedge clk);
    model_edge(r, b, s);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 4'b0010, 1'b0);
    tick(1'b1, 4'b0010, 1'b1);
    checks++; if (dir !== 2'd1) begin errors++; $display("FAIL reset_dir: got %0d want 1", dir); end
    checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL reset_qc: got %0d want 0", q_count); end
    checks++; if (turned !== 1'b0) begin errors++; $display("FAIL reset_turned: got %0d want 0", turned); end
    checks++; if (rejected !== 1'b0) begin errors++; $display("FAIL reset_rej: got %0d want 0", rejected); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'b0010, 1'b0);
      checks++; if (dir !== 2'd1) begin errors++; $display("FAIL held_dir: got %0d want 1", dir); end
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL held_qc: got %0d want 0", q_count); end
      checks++; if (rejected !== 1'b0) begin errors++; $display("FAIL held_rej: got %0d want 0", rejected); end
    end
    tick(1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_single_turn();
    do_reset();
    tick(1'b0, 4'b0001, 1'b0);
    checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL turn_qc_lat: got %0d want 0", q_count); end
    tick(1'b0, 4'b0001, 1'b0);
    checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL turn_qc: got %0d want 1", q_count); end
    checks++; if (rejected !== 1'b0) begin errors++; $display("FAIL turn_rej: got %0d want 0", rejected); end
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b1);
    checks++; if (dir !== 2'd0) begin errors++; $display("FAIL turn_dir: got %0d want 0", dir); end
    checks++; if (turned !== 1'b1) begin errors++; $display("FAIL turn_pulse: got %0d want 1", turned); end
    checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL turn_qc_pop: got %0d want 0", q_count); end
    tick(1'b0, 4'b0000, 1'b0);
    checks++; if (turned !== 1'b0) begin errors++; $display("FAIL turn_pulse_end: got %0d want 0", turned); end
    tick(1'b0, 4'b0000, 1'b1);
    checks++; if (turned !== 1'b0 || dir !== 2'd0) begin
      errors++; $display("FAIL turn_empty_step: got turned=%0d dir=%0d want 0 0", turned, dir);
    end
  endtask

  task automatic test_reject();
    logic [3:0] pats [2];
    pats[0] = 4'b1000;  // left: reverse of right
    pats[1] = 4'b0010;  // right: same as heading
    do_reset();
    for (int p = 0; p < 2; p++) begin
      tick(1'b0, pats[p], 1'b0);
      tick(1'b0, pats[p], 1'b0);
      checks++; if (rejected !== 1'b1) begin errors++; $display("FAIL rej_pulse%0d: got %0d want 1", p, rejected); end
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL rej_qc%0d: got %0d want 0", p, q_count); end
      tick(1'b0, 4'b0000, 1'b0);
      checks++; if (rejected !== 1'b0) begin errors++; $display("FAIL rej_end%0d: got %0d want 0", p, rejected); end
    end
  endtask

  task automatic test_queue_full();
    logic [3:0] pats [3];
    logic [1:0] want_qc [3];
    logic       want_rej [3];
    logic [1:0] want_dir [2];
    pats[0] = 4'b0001; pats[1] = 4'b1000; pats[2] = 4'b0100;
`ifdef SNAKE_DIR_QUEUE_EN
    want_qc[0] = 2'd1; want_qc[1] = 2'd2; want_qc[2] = 2'd2;
    want_rej[0] = 1'b0; want_rej[1] = 1'b0; want_rej[2] = 1'b1;
    want_dir[0] = 2'd0; want_dir[1] = 2'd3;
`else
    want_qc[0] = 2'd1; want_qc[1] = 2'd1; want_qc[2] = 2'd1;
    want_rej[0] = 1'b0; want_rej[1] = 1'b1; want_rej[2] = 1'b0;
    want_dir[0] = 2'd2; want_dir[1] = 2'd2;
`endif
    do_reset();
    for (int p = 0; p < 3; p++) begin
      tick(1'b0, pats[p], 1'b0);
      tick(1'b0, pats[p], 1'b0);
      checks++; if (q_count !== want_qc[p]) begin errors++; $display("FAIL full_qc%0d: got %0d want %0d", p, q_count, want_qc[p]); end
      checks++; if (rejected !== want_rej[p]) begin errors++; $display("FAIL full_rej%0d: got %0d want %0d", p, rejected, want_rej[p]); end
      tick(1'b0, 4'b0000, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 4'b0000, 1'b1);
      checks++; if (dir !== want_dir[k]) begin errors++; $display("FAIL full_dir%0d: got %0d want %0d", k, dir, want_dir[k]); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick(1'b0, 4'b0101, 1'b0);
    tick(1'b0, 4'b0101, 1'b0);
    checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL simul_qc: got %0d want 1", q_count); end
    checks++; if (rejected !== 1'b0) begin errors++; $display("FAIL simul_rej: got %0d want 0", rejected); end
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b1);
    checks++; if (dir !== 2'd0) begin errors++; $display("FAIL simul_dir: got %0d want 0", dir); end
    tick(1'b0, 4'b0000, 1'b0);
    checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL simul_qc_end: got %0d want 0", q_count); end
  endtask

  task automatic test_step_push();
    logic [1:0] want_qc;
`ifdef SNAKE_DIR_QUEUE_EN
    want_qc = 2'd2;
`else
    want_qc = 2'd1;
`endif
    // Empty buffer: press lands in the same cycle as a step, applies on the next.
    do_reset();
    tick(1'b0, 4'b0001, 1'b0);
    tick(1'b0, 4'b0001, 1'b1);
    checks++; if (dir !== 2'd1 || turned !== 1'b0) begin
      errors++; $display("FAIL sp_empty_dir: got dir=%0d turned=%0d want 1 0", dir, turned);
    end
    checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL sp_empty_qc: got %0d want 1", q_count); end
    tick(1'b0, 4'b0000, 1'b1);
    checks++; if (dir !== 2'd0) begin errors++; $display("FAIL sp_empty_next: got %0d want 0", dir); end

    // Full [0,3]: pop and push in one cycle.
    do_reset();
    tick(1'b0, 4'b0001, 1'b0); tick(1'b0, 4'b0001, 1'b0); tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b1000, 1'b0); tick(1'b0, 4'b1000, 1'b0); tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0100, 1'b0);
    tick(1'b0, 4'b0100, 1'b1);
    checks++; if (dir !== 2'd0 || turned !== 1'b1) begin
      errors++; $display("FAIL sp_full_dir: got dir=%0d turned=%0d want 0 1", dir, turned);
    end
    checks++; if (rejected !== 1'b0) begin errors++; $display("FAIL sp_full_rej: got %0d want 0", rejected); end
    checks++; if (q_count !== want_qc) begin errors++; $display("FAIL sp_full_qc: got %0d want %0d", q_count, want_qc); end
    tick(1'b1, 4'b0100, 1'b1);
    checks++; if (q_count !== 2'd0 || dir !== 2'd1) begin
      errors++; $display("FAIL sp_rst: got qc=%0d dir=%0d want 0 1", q_count, dir);
    end
    tick(1'b0, 4'b0100, 1'b0);
    tick(1'b0, 4'b0100, 1'b1);
    checks++; if (q_count !== 2'd0 || rejected !== 1'b0 || dir !== 2'd1) begin
      errors++; $display("FAIL sp_after_rst: got qc=%0d rej=%0d dir=%0d want 0 0 1", q_count, rejected, dir);
    end
    tick(1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] lv;
    logic       r, s;
    int         k;
    lv = 4'b0000;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(0, 3);
        lv[k] = ~lv[k];
      end
      if ($urandom_range(0, 40) == 0) lv = 4'($urandom);
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      tick(r, lv, s);
      checks++; if (dir !== m_dir) begin errors++; $display("FAIL rnd_dir c%0d: got %0d want %0d", c, dir, m_dir); end
      checks++; if (turned !== m_turned) begin errors++; $display("FAIL rnd_turned c%0d: got %0d want %0d", c, turned, m_turned); end
      checks++; if (rejected !== m_rejected) begin errors++; $display("FAIL rnd_rej c%0d: got %0d want %0d", c, rejected, m_rejected); end
      checks++; if (q_count !== 2'(mq.size())) begin errors++; $display("FAIL rnd_qc c%0d: got %0d want %0d", c, q_count, mq.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_turn();
    test_reject();
    test_queue_full();
    test_simultaneous();
    test_step_push();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
